// File: rtl/st_adapter_pkg.sv
// Shared constants, word bundle type and EOP helper for the Avalon-ST data format adapters.
// Optional error handling: ST_UNPACK_ERROR_EN.
package st_adapter_pkg;

   localparam int unsigned SYMBOL_W   = 8;
   localparam int unsigned IN_SYMBOLS = 4;
   localparam int unsigned EMPTY_W    = $clog2(IN_SYMBOLS);
   localparam int unsigned WORD_W     = SYMBOL_W * IN_SYMBOLS;

   typedef struct packed {
      logic [WORD_W-1:0]  data;
      logic               sop;
      logic               eop;
      logic [EMPTY_W-1:0] empty;
`ifdef ST_UNPACK_ERROR_EN
      logic               err;
`endif
   } st_word_t;

   // Index of the final valid symbol; empty only counts on the EOP word.
   function automatic logic [EMPTY_W-1:0] empty_to_last_idx(input logic               eop,
                                                            input logic [EMPTY_W-1:0] empty);
      logic [EMPTY_W-1:0] w_full;
      w_full = EMPTY_W'(IN_SYMBOLS - 1);
      return eop ? (w_full - empty) : w_full;
   endfunction

endpackage

// File: rtl/st_out_reg_stage.sv
// Generic registered Avalon-ST source stage: payload registers plus the advance condition.
// Shared by the wide-to-narrow and narrow-to-wide adapters.
module st_out_reg_stage #(
   parameter int unsigned PAYLOAD_W = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic                 out_ready,
   output logic                 adv,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_payload;

   // Stage may take a new beat when the sink drains it or it is empty.
   assign adv         = out_ready || !r_valid;
   assign out_valid   = r_valid;
   assign out_payload = r_payload;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid   <= 1'b0;
         r_payload <= '0;
      end else if (adv) begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_payload <= in_payload;
         end
      end
   end

endmodule

// File: rtl/st_word_to_byte_adapter.sv
// Avalon-ST wide-to-narrow adapter: 32-bit words out as big-endian 8-bit symbols.
// Define ST_UNPACK_ERROR_EN to add in_error/out_error with per-packet sticky error.
module st_word_to_byte_adapter
   import st_adapter_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   output logic                in_ready,
   input  logic                in_valid,
   input  logic [WORD_W-1:0]   in_data,
   input  logic                in_startofpacket,
   input  logic                in_endofpacket,
   input  logic [EMPTY_W-1:0]  in_empty,
`ifdef ST_UNPACK_ERROR_EN
   input  logic                in_error,
`endif
   input  logic                out_ready,
   output logic                out_valid,
   output logic [SYMBOL_W-1:0] out_data,
   output logic                out_startofpacket,
`ifdef ST_UNPACK_ERROR_EN
   output logic                out_endofpacket,
   output logic                out_error
`else
   output logic                out_endofpacket
`endif
);

`ifdef ST_UNPACK_ERROR_EN
   localparam int unsigned PAYLOAD_W = SYMBOL_W + 3;
`else
   localparam int unsigned PAYLOAD_W = SYMBOL_W + 2;
`endif

   st_word_t            w_in_word;
   logic [EMPTY_W-1:0]  w_in_last;
   logic                w_accept;
   logic                w_adv;
   logic                w_load;
   logic                w_last;
   logic                w_release;
   logic [SYMBOL_W-1:0] w_byte;
   logic                w_sop;
   logic                w_eop;
   logic [PAYLOAD_W-1:0] w_stage_in;
   logic [PAYLOAD_W-1:0] w_stage_out;

   logic                r_hold_valid;
   logic [WORD_W-1:0]   r_hold_data;
   logic                r_hold_sop;
   logic                r_hold_eop;
   logic [EMPTY_W-1:0]  r_last_idx;
   logic [EMPTY_W-1:0]  r_idx;

   always_comb begin
      w_in_word       = '0;
      w_in_word.data  = in_data;
      w_in_word.sop   = in_startofpacket;
      w_in_word.eop   = in_endofpacket;
      w_in_word.empty = in_empty;
`ifdef ST_UNPACK_ERROR_EN
      w_in_word.err   = in_error;
`endif
   end

   assign w_in_last = empty_to_last_idx(w_in_word.eop, w_in_word.empty);
   assign w_last    = (r_idx == r_last_idx);
   assign w_load    = r_hold_valid && w_adv;
   assign w_release = w_load && w_last;
   // Open for a new word in the cycle the last byte of the held word loads.
   assign in_ready  = !r_hold_valid || (w_adv && w_last);
   assign w_accept  = in_valid && in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_valid <= 1'b0;
         r_hold_data  <= '0;
         r_hold_sop   <= 1'b0;
         r_hold_eop   <= 1'b0;
         r_last_idx   <= '0;
         r_idx        <= '0;
      end else begin
         if (w_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= w_in_word.data;
            r_hold_sop   <= w_in_word.sop;
            r_hold_eop   <= w_in_word.eop;
            r_last_idx   <= w_in_last;
            r_idx        <= '0;
         end else if (w_release) begin
            r_hold_valid <= 1'b0;
            r_idx        <= '0;
         end else if (w_load) begin
            r_idx <= r_idx + EMPTY_W'(1);
         end
      end
   end

   // Big-endian symbol select: idx 0 takes the most significant byte.
   always_comb begin
      w_byte = '0;
      for (int i = 0; i < int'(IN_SYMBOLS); i++) begin
         if (r_idx == EMPTY_W'(i)) begin
            w_byte = r_hold_data[(IN_SYMBOLS-1-i)*SYMBOL_W +: SYMBOL_W];
         end
      end
   end

   assign w_sop = r_hold_sop && (r_idx == '0);
   assign w_eop = r_hold_eop && w_last;

`ifdef ST_UNPACK_ERROR_EN
   logic r_hold_err;
   logic r_sticky_err;
   logic w_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hold_err   <= 1'b0;
         r_sticky_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_hold_err <= w_in_word.err;
         end
         // A newly captured errored word outranks the clear from the EOP byte.
         if (w_load && w_eop) begin
            r_sticky_err <= 1'b0;
         end
         if (w_accept && w_in_word.err) begin
            r_sticky_err <= 1'b1;
         end
      end
   end

   assign w_err      = r_hold_err || (w_eop && r_sticky_err);
   assign w_stage_in = {w_byte, w_sop, w_eop, w_err};
   assign {out_data, out_startofpacket, out_endofpacket, out_error} = w_stage_out;
`else
   assign w_stage_in = {w_byte, w_sop, w_eop};
   assign {out_data, out_startofpacket, out_endofpacket} = w_stage_out;
`endif

   st_out_reg_stage #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_out_stage (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (r_hold_valid),
      .in_payload  (w_stage_in),
      .out_ready   (out_ready),
      .adv         (w_adv),
      .out_valid   (out_valid),
      .out_payload (w_stage_out)
   );

endmodule

// File: tb/tb_st_word_to_byte_adapter.sv
// Scoreboard bench for st_word_to_byte_adapter: directed words, byte expectations queued by hand.
// Exercises the error path when ST_UNPACK_ERROR_EN is defined.
module tb_st_word_to_byte_adapter;

   typedef struct {
      logic [7:0] d;
      logic       s;
      logic       e;
      logic       r;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_ready;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_sop = 1'b0;
   logic        in_eop = 1'b0;
   logic [1:0]  in_empty = '0;
   logic        in_error = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sop;
   logic        out_eop;
   logic        out_error;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rdy_mode = 0;
   int   rdy_phase = 0;
   bit   chk_inrdy = 1'b0;
   logic       prev_stall = 1'b0;
   logic [9:0] prev_out = '0;

   st_word_to_byte_adapter dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .in_ready          (in_ready),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_startofpacket  (in_sop),
      .in_endofpacket    (in_eop),
      .in_empty          (in_empty),
`ifdef ST_UNPACK_ERROR_EN
      .in_error          (in_error),
      .out_error         (out_error),
`endif
      .out_ready         (out_ready),
      .out_valid         (out_valid),
      .out_data          (out_data),
      .out_startofpacket (out_sop),
      .out_endofpacket   (out_eop)
   );

`ifndef ST_UNPACK_ERROR_EN
   assign out_error = 1'b0;
`endif

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      #2;
      if (rdy_mode == 0) begin
         out_ready = 1'b1;
      end else begin
         out_ready = ((rdy_phase % 3) == 0);
         rdy_phase = rdy_phase + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic expect_byte(input logic [7:0] d, input logic s, input logic e, input logic r);
      exp_t x;
      x.d = d; x.s = s; x.e = e; x.r = r;
      q.push_back(x);
   endtask

   // Monitor: compares every accepted byte against the scoreboard head.
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_hold", {out_data, out_sop, out_eop}, prev_out);
         end
         if (chk_inrdy) begin
            if (q.size() >= 3)      check("in_ready_busy", in_ready, 1'b0);
            else if (q.size() == 2) check("in_ready_last", in_ready, out_ready);
            else if (q.size() == 1) check("in_ready_free", in_ready, 1'b1);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL unexpected_byte: got %0h expected none", out_data);
            end else begin
               exp_t x;
               x = q.pop_front();
               check("byte_data", out_data, x.d);
               check("byte_sop", out_sop, x.s);
               check("byte_eop", out_eop, x.e);
`ifdef ST_UNPACK_ERROR_EN
               check("byte_err", out_error, x.r);
`endif
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_data, out_sop, out_eop};
      end
   end

   task automatic send(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp,
                       input logic er, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e; in_empty = emp; in_error = er;
      #1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL send_timeout: got in_ready 0 expected 1 for word %0h", d);
      end
      acc = cyc + 1;
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (q.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s_drain: got %0d bytes pending expected 0", name, q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1, a2;
      repeat (2) @(negedge clk);
      #1;
      check("reset_valid", out_valid, 1'b0);
      check("reset_data", out_data, 8'h00);
      check("reset_sop", out_sop, 1'b0);
      check("reset_eop", out_eop, 1'b0);
      check("reset_err", out_error, 1'b0);
      check("reset_in_ready", in_ready, 1'b1);
      @(negedge clk);
      reset_n = 1'b1;

      // 1: single-word packet
      expect_byte(8'hA1, 1, 0, 0); expect_byte(8'hB2, 0, 0, 0);
      expect_byte(8'hC3, 0, 0, 0); expect_byte(8'hD4, 0, 1, 0);
      send(32'hA1B2C3D4, 1, 1, 2'd0, 0, a1);
      idle();
      wait_empty("t1");
      @(negedge clk);
      #1;
      check("t1_valid_after_eop", out_valid, 1'b0);

      // 2: two-word packet, zero bubble between words
      expect_byte(8'h01, 1, 0, 0); expect_byte(8'h02, 0, 0, 0);
      expect_byte(8'h03, 0, 0, 0); expect_byte(8'h04, 0, 0, 0);
      expect_byte(8'h05, 0, 0, 0); expect_byte(8'h06, 0, 1, 0);
      send(32'h01020304, 1, 0, 2'd0, 0, a1);
      send(32'h05060708, 0, 1, 2'd2, 0, a2);
      idle();
      check("t2_accept_gap", a2 - a1, 4);
      wait_empty("t2");

      // 3: empty=3, single byte with sop and eop
      expect_byte(8'hEE, 1, 1, 0);
      send(32'hEE000000, 1, 1, 2'd3, 0, a1);
      idle();
      @(negedge clk);
      #1;
      check("t3_in_ready_next", in_ready, 1'b1);
      wait_empty("t3");

      // 4: backpressure pattern 1,0,0
      repeat (2) @(negedge clk);
      expect_byte(8'h11, 1, 0, 0); expect_byte(8'h22, 0, 0, 0);
      expect_byte(8'h33, 0, 0, 0); expect_byte(8'h44, 0, 1, 0);
      rdy_phase = 0;
      rdy_mode = 1;
      send(32'h11223344, 1, 1, 2'd0, 0, a1);
      chk_inrdy = 1'b1;
      idle();
      wait_empty("t4");
      chk_inrdy = 1'b0;
      rdy_mode = 0;
      repeat (3) @(negedge clk);

      // 5: reset after the second byte of a word
      expect_byte(8'h12, 1, 0, 0); expect_byte(8'h34, 0, 0, 0);
      send(32'h12345678, 1, 1, 2'd0, 0, a1);
      idle();
      wait_empty("t5a");
      #1;
      reset_n = 1'b0;
      #1;
      check("t5_rst_valid", out_valid, 1'b0);
      check("t5_rst_data", out_data, 8'h00);
      check("t5_rst_sop", out_sop, 1'b0);
      check("t5_rst_eop", out_eop, 1'b0);
      check("t5_rst_in_ready", in_ready, 1'b1);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      expect_byte(8'hCA, 1, 0, 0); expect_byte(8'hFE, 0, 0, 0);
      expect_byte(8'hBA, 0, 0, 0); expect_byte(8'hBE, 0, 1, 0);
      send(32'hCAFEBABE, 1, 1, 2'd0, 0, a1);
      idle();
      wait_empty("t5b");

`ifdef ST_UNPACK_ERROR_EN
      // 6: errored first word marks its bytes and the packet's EOP byte
      expect_byte(8'h10, 1, 0, 1); expect_byte(8'h20, 0, 0, 1);
      expect_byte(8'h30, 0, 0, 1); expect_byte(8'h40, 0, 0, 1);
      expect_byte(8'h50, 0, 0, 0); expect_byte(8'h60, 0, 0, 0);
      expect_byte(8'h70, 0, 0, 0); expect_byte(8'h80, 0, 1, 1);
      expect_byte(8'h0A, 1, 0, 0); expect_byte(8'h0B, 0, 0, 0);
      expect_byte(8'h0C, 0, 0, 0); expect_byte(8'h0D, 0, 1, 0);
      send(32'h10203040, 1, 0, 2'd0, 1, a1);
      send(32'h50607080, 0, 1, 2'd0, 0, a1);
      send(32'h0A0B0C0D, 1, 1, 2'd0, 0, a1);
      idle();
      wait_empty("t6");
`endif

      repeat (3) @(negedge clk);
      check("final_queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
